pic32_spi_master: RTL and testbench

- SPI master for the FPGA↔PIC32 serial link. It drives chip-select, clock and data into an SPI slave port and samples that port's data-out and interrupt lines.
- Used on the board as the initiating end of the bidirectional link, and in the bench as a driver for the SOPC slave.
- Converts parallel register-access commands into one fixed-length frame: R/W bit, then address, then data, MSB first, SPI mode 0.

---
 rtl/pic32_spi_master.sv | 171 +++++++++++++++++
 tb/tb_pic32_spi_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic32_spi_master.sv
// pic32_spi_master: SPI mode-0 master for the FPGA <-> PIC32 register link.
// Each command becomes one frame of {rw, addr, data}, sent MSB first.
// The frame length is FL = 1 + ADDR_W + DATA_W.
// Optional feature: define PIC32_SPI_SINT_IRQ_EN to enable it.
//   When defined, spi_sint is synchronised and its rising edge latches irq.
//   When undefined, irq is tied low.
module pic32_spi_master #(
  parameter int CLK_DIV = 4,  // clk_clk cycles per SCLK half-period, >= 2
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  input  logic              spi_sint,
  output logic              irq,
  input  logic              irq_clr
);

  localparam int FL    = 1 + ADDR_W + DATA_W;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FL);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FL - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [FL-1:0]     tx;
  logic [DATA_W-1:0] rx;
  logic              tick;
  logic              last_bit;

  // tick marks the final clk_clk cycle of a SETUP, HOLD, GAP or half-bit interval.
  assign tick      = (div_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign cmd_ready = (state == IDLE);
  // MOSI is the MSB of the transmit register.
  // The register is loaded on accept, shifted on falling SCLK, and cleared after HOLD.
  assign spi_mosi  = tx[FL-1];

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_next;
  end

  // Next-state logic: each phase lasts a whole number of CLK_DIV intervals.
  // NOTE: state_next gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   if (tick) state_next = SHIFT;
      SHIFT:   if (tick && !spi_sclk && last_bit) state_next = HOLD;
      HOLD:    if (tick) state_next = GAP;
      GAP:     if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Interval counter.
  // Held at zero in IDLE, so the first SETUP cycle always starts at count 0.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || state == IDLE) div_cnt <= '0;
    else if (tick)                       div_cnt <= '0;
    else                                 div_cnt <= div_cnt + DIV_W'(1);
  end

  // Frame datapath: shift registers, chip select, SCLK and the response.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            tx       <= {cmd_rw, cmd_addr, cmd_wdata};
            bit_cnt  <= '0;
            spi_cs_n <= 1'b0;
          end
        end
        SETUP: begin
          // The first rising SCLK edge: sample MISO for bit 0.
          if (tick) begin
            spi_sclk <= 1'b1;
            rx       <= {rx[DATA_W-2:0], spi_miso};
          end
        end
        SHIFT: begin
          if (tick) begin
            if (spi_sclk) begin
              // Falling edge: present the next bit, but hold the last one.
              spi_sclk <= 1'b0;
              if (!last_bit) tx <= {tx[FL-2:0], 1'b0};
            end else if (!last_bit) begin
              // Rising edge of the following bit: sample MISO.
              spi_sclk <= 1'b1;
              rx       <= {rx[DATA_W-2:0], spi_miso};
              bit_cnt  <= bit_cnt + BIT_W'(1);
            end
          end
        end
        HOLD: begin
          if (tick) begin
            spi_cs_n  <= 1'b1;
            tx        <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIC32_SPI_SINT_IRQ_EN
  logic sint_meta;
  logic sint_sync;
  logic sint_prev;

  // Synchronise spi_sint, detect its rising edge and latch irq.
  // If a new edge and irq_clr arrive together, the set takes priority.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sint_meta <= 1'b0;
      sint_sync <= 1'b0;
      sint_prev <= 1'b0;
      irq       <= 1'b0;
    end else begin
      sint_meta <= spi_sint;
      sint_sync <= sint_meta;
      sint_prev <= sint_sync;
      if (sint_sync && !sint_prev) irq <= 1'b1;
      else if (irq_clr)            irq <= 1'b0;
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = spi_sint ^ irq_clr;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_pic32_spi_master.sv
// tb_pic32_spi_master: scoreboard bench for pic32_spi_master.
// The stimulus pushes the expected frame and response for each command.
// A monitor rebuilds each frame from the SPI pins, then pops and compares.
// A MISO slave model shifts out a chosen word, one bit per falling SCLK edge.
module tb_pic32_spi_master;

  localparam int CLK_DIV = 4;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int FL      = 1 + ADDR_W + DATA_W;
  localparam int CS_LOW  = (2 + 2 * FL) * CLK_DIV;

  typedef struct {
    logic [FL-1:0]     frame;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_sint;
  logic              irq;
  logic              irq_clr;

  exp_t          exp_q[$];
  logic [FL-1:0] miso_q[$];
  bit            abort_frame = 1'b0;
  int            tests = 0;
  int            fails = 0;

  pic32_spi_master #(
    .CLK_DIV(CLK_DIV),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .spi_cs_n     (spi_cs_n),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_sint     (spi_sint),
    .irq          (irq),
    .irq_clr      (irq_clr)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FL-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[FL-1:0];
  endfunction

  // Queue the expected result, present the command, and hold it until accepted.
  task automatic issue(input logic rw, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [FL-1:0] miso_word);
    exp_t e;
    int   n = 0;
    e.frame = {rw, addr, wdata};
    e.rdata = miso_word[DATA_W-1:0];
    exp_q.push_back(e);
    miso_q.push_back(miso_word);
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 5000) begin
      @(posedge clk_clk); #1;
      n++;
    end
    if (n == 5000) check("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk_clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk_clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_sclk_rises(input int count);
    int   seen = 0;
    int   cyc  = 0;
    logic prev = spi_sclk;
    while (seen < count && cyc < 5000) begin
      @(posedge clk_clk); #1;
      cyc++;
      if (spi_sclk && !prev) seen++;
      prev = spi_sclk;
    end
    if (seen < count) check("sclk_timeout", 64'(seen), 64'(count));
  endtask

  // SPI slave: load a word when CS falls, then advance MISO on each falling SCLK edge.
  initial begin : slave
    logic          prev_cs;
    logic          prev_sclk;
    logic [FL-1:0] word;
    int            idx;
    prev_cs   = 1'b1;
    prev_sclk = 1'b0;
    word      = '0;
    idx       = -1;
    spi_miso  = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
        word     = (miso_q.size() > 0) ? miso_q.pop_front() : '0;
        spi_miso = word[FL-1];
        idx      = FL - 2;
      end else if (spi_cs_n === 1'b0 && spi_sclk === 1'b0 && prev_sclk === 1'b1 && idx >= 0) begin
        spi_miso = word[idx];
        idx--;
      end
      prev_cs   = spi_cs_n;
      prev_sclk = spi_sclk;
    end
  end

  // Monitor: rebuild each frame from the pins and compare it when CS rises.
  initial begin : monitor
    logic          prev_cs;
    logic          prev_sclk;
    int            low_cnt;
    int            high_cnt;
    int            pulses;
    logic [FL-1:0] got;
    bit            seen;
    exp_t          e;
    prev_cs   = 1'b1;
    prev_sclk = 1'b0;
    low_cnt   = 0;
    high_cnt  = 0;
    pulses    = 0;
    got       = '0;
    seen      = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
        if (seen) check("cs_gap_min", 64'(high_cnt >= CLK_DIV), 64'd1);
        low_cnt = 0;
        pulses  = 0;
        got     = '0;
      end
      if (spi_cs_n === 1'b1 && prev_cs === 1'b0) begin
        seen     = 1'b1;
        high_cnt = 0;
        if (abort_frame) begin
          check("abort_no_rsp", 64'(rsp_valid), 64'd0);
          if (exp_q.size() > 0) e = exp_q.pop_front();
          abort_frame = 1'b0;
        end else if (exp_q.size() == 0) begin
          check("frames_pending", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("mosi_frame", 64'(got), 64'(e.frame));
          check("sclk_pulses", 64'(pulses), 64'(FL));
          check("cs_low_cycles", 64'(low_cnt), 64'(CS_LOW));
          check("rsp_valid_at_cs_rise", 64'(rsp_valid), 64'd1);
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        end
      end else if (rsp_valid === 1'b1) begin
        check("spurious_rsp", 64'(rsp_valid), 64'd0);
      end
      if (spi_cs_n === 1'b0) low_cnt++;
      else                   high_cnt++;
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0 && spi_cs_n === 1'b0) begin
        pulses++;
        got = {got[FL-2:0], spi_mosi};
      end
      prev_cs   = spi_cs_n;
      prev_sclk = spi_sclk;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d frames pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin : stim
    logic [FL-1:0] w;
    reset_reset_n = 1'b0;
    cmd_valid     = 1'b0;
    cmd_rw        = 1'b0;
    cmd_addr      = '0;
    cmd_wdata     = '0;
    spi_sint      = 1'b0;
    irq_clr       = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_cs_n", 64'(spi_cs_n), 64'd1);
    check("rst_sclk", 64'(spi_sclk), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;

    // Directed write.
    issue(1'b0, 7'h15, 32'hDEADBEEF, rand_word());
    cmd_valid = 1'b0;
    wait_drain();

    // Directed read: the slave returns 0x12345678 in the last 32 bits.
    w = rand_word();
    w[DATA_W-1:0] = 32'h12345678;
    issue(1'b1, 7'h01, $urandom, w);
    cmd_valid = 1'b0;
    wait_drain();

    // Back-to-back commands, with cmd_valid held high throughout.
    issue(1'(($urandom)), 7'($urandom), $urandom, rand_word());
    issue(1'(($urandom)), 7'($urandom), $urandom, rand_word());
    cmd_valid = 1'b0;
    wait_drain();

    // Randomised commands.
    for (int i = 0; i < 6; i++) begin
      issue(1'(($urandom)), 7'($urandom), $urandom, rand_word());
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk_clk);
      #1;
    end
    wait_drain();

    // One-cycle reset pulse in the middle of a frame (bit 20).
    issue(1'b1, 7'($urandom), $urandom, rand_word());
    cmd_valid = 1'b0;
    wait_sclk_rises(21);
    abort_frame   = 1'b1;
    reset_reset_n = 1'b0;
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    check("abort_cs_n", 64'(spi_cs_n), 64'd1);
    check("abort_sclk", 64'(spi_sclk), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_mosi", 64'(spi_mosi), 64'd0);
    repeat (2 * CLK_DIV) @(posedge clk_clk);
    #1;
    wait_drain();
    issue(1'(($urandom)), 7'($urandom), $urandom, rand_word());
    cmd_valid = 1'b0;
    wait_drain();

`ifdef PIC32_SPI_SINT_IRQ_EN
    // A one-cycle sint pulse sets irq three cycles after the rise.
    spi_sint = 1'b1;
    @(posedge clk_clk); #1;
    spi_sint = 1'b0;
    @(posedge clk_clk); #1;
    check("irq_before_latency", 64'(irq), 64'd0);
    @(posedge clk_clk); #1;
    check("irq_after_3", 64'(irq), 64'd1);
    repeat (3) @(posedge clk_clk);
    #1;
    // A clear that coincides with a new detected edge loses to the set.
    spi_sint = 1'b1;
    @(posedge clk_clk); #1;
    spi_sint = 1'b0;
    @(posedge clk_clk); #1;
    irq_clr = 1'b1;
    @(posedge clk_clk); #1;
    irq_clr = 1'b0;
    check("irq_set_wins", 64'(irq), 64'd1);
    // A clear on its own drops irq on the next cycle.
    repeat (2) @(posedge clk_clk);
    #1;
    irq_clr = 1'b1;
    @(posedge clk_clk); #1;
    irq_clr = 1'b0;
    check("irq_cleared", 64'(irq), 64'd0);
`else
    // With the feature disabled, irq stays low whatever sint and irq_clr do.
    for (int i = 0; i < 10; i++) begin
      spi_sint = ~spi_sint;
      irq_clr  = (i == 5);
      @(posedge clk_clk); #1;
      check("irq_tied_low", 64'(irq), 64'd0);
    end
    spi_sint = 1'b0;
    irq_clr  = 1'b0;
`endif

    repeat (4) @(posedge clk_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
